sha256_nonce_scheduler: RTL and testbench
=========================================

Name: sha256_nonce_scheduler

Overview:
- Sequences a pool of NUM_CORES identical SHA-256 nonce-hash cores through a nonce sweep of NUM_NONCES values.
- Dispatches each nonce to a free core and collects each core's result word.
- Serialises results onto a single memory write port at output_addr + nonce.
- Sits between the top-level bitcoin_hash control and the replicated hash cores, replacing a single core looping over nonces.

Parameters:
NUM_CORES, 4, number of hash cores managed (1..16)
NUM_NONCES, 16, nonces swept per run, values 0..NUM_NONCES-1 (1..256)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  run request, sampled in IDLE only
output_addr  input  16  base word address for results, latched when start is accepted
done  output  1  one-cycle pulse when the last result write has been issued
core_start  output  NUM_CORES  one-hot, one-cycle pulse launching core i
core_nonce  output  32  nonce for the launched core, valid only while core_start is nonzero
core_done  input  NUM_CORES  one-cycle pulse from core i, result valid in the same cycle
core_result  input  NUM_CORES*32  result word of core i in bits [32*i+31:32*i]
mem_we  output  1  memory write strobe
mem_addr  output  16  write address
mem_write_data  output  32  write data

Behaviour:
- Reset (asynchronous, any state):
  - All outputs go to 0 and state goes to IDLE.
  - busy, pending and tag registers, the nonce counter, the write counter and the round-robin pointer all clear.
  - A reset in the middle of a run abandons it; no further writes occur.
- All outputs are registered.
- States are IDLE, RUN, DONE.
- IDLE:
  - start=1 latches output_addr, clears the counters, and moves to RUN.
  - The first core_start pulse appears in the cycle after start is accepted.
- RUN, dispatch:
  - Each cycle, if next_nonce < NUM_NONCES and at least one core has busy=0, pulse core_start for the lowest-index free core.
  - In the same cycle: drive core_nonce = next_nonce zero-extended, set tag[i] = next_nonce, set busy[i], and increment next_nonce.
  - At most one dispatch per cycle. Nonces are issued strictly in ascending order.
- RUN, capture:
  - core_done[i] while busy[i]=1 and pending[i]=0 stores core_result slice i into result[i] and sets pending[i].
  - core_done for a core with busy=0, or with pending already set, is ignored.
  - Multiple core_done bits in the same cycle are all captured.
- RUN, write arbitration:
  - Each cycle, if any pending bit is set, select one entry round-robin, searching upward from rr_ptr with wrap.
  - Register mem_we=1, mem_addr = latched_addr + tag[sel] (16-bit modulo wrap), mem_write_data = result[sel].
  - On that edge: clear pending[sel] and busy[sel], set rr_ptr = sel+1 mod NUM_CORES, increment the write count.
  - The freed core may be dispatched in the next cycle.
  - mem_we is 0 in every cycle without a selected entry.
- Latency: with no contention, core_done high in cycle c gives mem_we high in cycle c+2.
- Throughput: at most one write and one dispatch per cycle.
- RUN to DONE: on the edge that issues write number NUM_NONCES.
- DONE: done=1 for exactly one cycle (the cycle after the final mem_we cycle), then IDLE.
- start is ignored in RUN and DONE. No queued restart.
- Counter widths:
  - next_nonce and the write count are 9 bits, so they can reach NUM_NONCES=256.
  - tag is 8 bits.

Test Plan:
1. Basic sweep:
   - Stimulus: output_addr=0x0100, each core returns 0xA5A50000|nonce 10 cycles after its start.
   - Required: exactly 16 writes at 0x0100..0x010F with matching data; core_nonce sequence 0..15; never more than 4 cores busy; single done pulse.
2. Out-of-order completion:
   - Stimulus: core latencies 20/5/12/3 for cores 0..3.
   - Required: writes follow completion order; every address equals base+tag and data matches that nonce; no duplicates.
3. Simultaneous completion:
   - Stimulus: all 4 cores pulse core_done in the same cycle, rr_ptr=2.
   - Required: 4 consecutive mem_we cycles serving cores 2,3,0,1; the freed cores are redispatched in the cycles that follow.
4. Address wrap:
   - Stimulus: output_addr=0xFFFC.
   - Required: addresses 0xFFFC..0xFFFF then 0x0000..0x000B.
5. Reset mid-run:
   - Stimulus: assert reset_n=0 after the 6th write.
   - Required: all outputs read 0 immediately. A new start then produces a full 16 writes beginning with core_nonce=0.
6. Illegal events:
   - Stimulus: core_done on an idle core; start asserted during RUN.
   - Required: no extra writes, no restart; the run completes normally with 16 writes.

Source files
------------

// File: rtl/sha256_nonce_scheduler.sv
// Nonce scheduler for a pool of SHA-256 cores: dispatches nonces in ascending order
// to free cores, captures results and serialises them onto one memory write port.
module sha256_nonce_scheduler #(
   parameter int unsigned NUM_CORES  = 4,
   parameter int unsigned NUM_NONCES = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [15:0]             output_addr,
   output logic                    done,
   output logic [NUM_CORES-1:0]    core_start,
   output logic [31:0]             core_nonce,
   input  logic [NUM_CORES-1:0]    core_done,
   input  logic [NUM_CORES*32-1:0] core_result,
   output logic                    mem_we,
   output logic [15:0]             mem_addr,
   output logic [31:0]             mem_write_data
);

   localparam int unsigned RRW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [8:0]  LAST = 9'(NUM_NONCES);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                     state_q, state_d;
   logic [15:0]                base_q, base_d;
   logic [8:0]                 nonce_q, nonce_d;
   logic [8:0]                 wcnt_q, wcnt_d;
   logic [NUM_CORES-1:0]       busy_q, busy_d;
   logic [NUM_CORES-1:0]       pend_q, pend_d;
   logic [NUM_CORES-1:0][7:0]  tag_q, tag_d;
   logic [NUM_CORES-1:0][31:0] res_q, res_d;
   logic [RRW-1:0]             rr_q, rr_d;
   logic                       done_q, done_d;
   logic [NUM_CORES-1:0]       cstart_q, cstart_d;
   logic [31:0]                cnonce_q, cnonce_d;
   logic                       we_q, we_d;
   logic [15:0]                waddr_q, waddr_d;
   logic [31:0]                wdata_q, wdata_d;

   logic                       disp_en;
   logic                       disp_found;
   logic                       wr_found;
   logic [NUM_CORES-1:0]       disp_busy;
   logic [8:0]                 disp_nonce;
   logic [RRW-1:0]             sel;

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      nonce_d    = nonce_q;
      wcnt_d     = wcnt_q;
      busy_d     = busy_q;
      pend_d     = pend_q;
      tag_d      = tag_q;
      res_d      = res_q;
      rr_d       = rr_q;
      done_d     = 1'b0;
      cstart_d   = '0;
      cnonce_d   = '0;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      disp_en    = 1'b0;
      disp_found = 1'b0;
      wr_found   = 1'b0;
      disp_busy  = busy_q;
      disp_nonce = nonce_q;
      sel        = '0;

      case (state_q)
         IDLE: begin
            // Accepting start also dispatches nonce 0 so core_start follows immediately.
            if (start) begin
               base_d     = output_addr;
               nonce_d    = '0;
               wcnt_d     = '0;
               busy_d     = '0;
               pend_d     = '0;
               rr_d       = '0;
               disp_busy  = '0;
               disp_nonce = '0;
               disp_en    = 1'b1;
               state_d    = RUN;
            end
         end
         RUN: begin
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
               if (core_done[i] && busy_q[i] && !pend_q[i]) begin
                  res_d[i]  = core_result[32*i +: 32];
                  pend_d[i] = 1'b1;
               end
            end
            // Round-robin as two passes: indices at or above rr_q first, then the wrap.
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
               if (!wr_found && pend_q[i] && (i >= 32'(rr_q))) begin
                  wr_found = 1'b1;
                  sel      = RRW'(i);
               end
            end
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
               if (!wr_found && pend_q[i]) begin
                  wr_found = 1'b1;
                  sel      = RRW'(i);
               end
            end
            if (wr_found) begin
               we_d        = 1'b1;
               waddr_d     = base_q + {8'h00, tag_q[sel]};
               wdata_d     = res_q[sel];
               pend_d[sel] = 1'b0;
               busy_d[sel] = 1'b0;
               rr_d        = (32'(sel) == NUM_CORES - 1) ? '0 : sel + 1'b1;
               wcnt_d      = wcnt_q + 9'd1;
               if (wcnt_d == LAST) state_d = DONE;
            end
            disp_en = 1'b1;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (disp_en && (disp_nonce < LAST)) begin
         for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (!disp_found && !disp_busy[i]) begin
               disp_found  = 1'b1;
               cstart_d[i] = 1'b1;
               cnonce_d    = {23'd0, disp_nonce};
               tag_d[i]    = disp_nonce[7:0];
               busy_d[i]   = 1'b1;
               nonce_d     = disp_nonce + 9'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         base_q   <= '0;
         nonce_q  <= '0;
         wcnt_q   <= '0;
         busy_q   <= '0;
         pend_q   <= '0;
         tag_q    <= '0;
         res_q    <= '0;
         rr_q     <= '0;
         done_q   <= 1'b0;
         cstart_q <= '0;
         cnonce_q <= '0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         nonce_q  <= nonce_d;
         wcnt_q   <= wcnt_d;
         busy_q   <= busy_d;
         pend_q   <= pend_d;
         tag_q    <= tag_d;
         res_q    <= res_d;
         rr_q     <= rr_d;
         done_q   <= done_d;
         cstart_q <= cstart_d;
         cnonce_q <= cnonce_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign done           = done_q;
   assign core_start     = cstart_q;
   assign core_nonce     = cnonce_q;
   assign mem_we         = we_q;
   assign mem_addr       = waddr_q;
   assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Bench for sha256_nonce_scheduler: behavioural core pool, scoreboard of expected
// writes (address = base + nonce, data derived from nonce) and a decoupled monitor.
module tb_sha256_nonce_scheduler;

   localparam int NC = 4;
   localparam int NN = 16;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic             start = 1'b0;
   logic [15:0]      output_addr = '0;
   logic             done;
   logic [NC-1:0]    core_start;
   logic [31:0]      core_nonce;
   logic [NC-1:0]    core_done = '0;
   logic [NC*32-1:0] core_result = '0;
   logic             mem_we;
   logic [15:0]      mem_addr;
   logic [31:0]      mem_write_data;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   exp_t        exp_q[$];
   logic [15:0] ord_q[$];
   int          start_q[$];
   int          ord_last = -1;
   int          wr_total = 0;
   int          wr_run = 0;
   int          last_wr = 0;
   int          done_cnt = 0;

   logic [15:0] base = '0;
   logic        strict = 1'b0;
   logic        hold_mode = 1'b0;
   logic        rand_lat = 1'b0;
   int          lat[NC] = '{10, 10, 10, 10};
   logic [NC-1:0] rel_mask = '0;
   int          rel_seq = 0;
   int          inj_seq = 0;

   logic [NC-1:0] active = '0;
   logic [NC-1:0] held = '0;
   int            cnt[NC];
   logic [8:0]    cnonce[NC];
   int            exp_nonce = 0;
   int            rel_seen = 0;
   int            inj_seen = 0;

   sha256_nonce_scheduler #(
      .NUM_CORES (NC),
      .NUM_NONCES(NN)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .output_addr   (output_addr),
      .done          (done),
      .core_start    (core_start),
      .core_nonce    (core_nonce),
      .core_done     (core_done),
      .core_result   (core_result),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_write_data(mem_write_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [31:0] res_fn(input logic [8:0] n);
      return 32'hA5A5_0000 | {23'd0, n};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tfail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   task automatic fire(input int i);
      core_done[i] = 1'b1;
      core_result[32*i +: 32] = res_fn(cnonce[i]);
      active[i] = 1'b0;
      exp_q.push_back('{addr: base + 16'(cnonce[i]), data: res_fn(cnonce[i]), cyc: cyc});
   endtask

   // Behavioural core pool: each launch completes after its latency, or on release when held.
   initial begin
      int ci;
      forever begin
         @(negedge clk);
         core_done = '0;
         if (!reset_n) begin
            active    = '0;
            held      = '0;
            exp_nonce = 0;
            rel_seen  = rel_seq;
            inj_seen  = inj_seq;
         end else begin
            if (done) exp_nonce = 0;
            if (rel_seq != rel_seen) begin
               rel_seen = rel_seq;
               for (int i = 0; i < NC; i++)
                  if (rel_mask[i] && active[i] && held[i]) begin
                     held[i] = 1'b0;
                     fire(i);
                  end
            end
            for (int i = 0; i < NC; i++)
               if (active[i] && !held[i]) begin
                  cnt[i]--;
                  if (cnt[i] <= 0) fire(i);
               end
            if (inj_seq != inj_seen) begin
               inj_seen = inj_seq;
               for (int i = 0; i < NC; i++)
                  if (!active[i] && !core_done[i] && !core_start[i]) begin
                     core_done[i] = 1'b1;
                     core_result[32*i +: 32] = $urandom;
                  end
            end
            if (core_start != '0) begin
               ci = 0;
               for (int i = NC - 1; i >= 0; i--) if (core_start[i]) ci = i;
               chk("start_onehot", $countones(core_start), 1);
               chk("nonce_seq", core_nonce, exp_nonce);
               chk("start_free_core", 32'(active[ci]), 0);
               if (start_q.size() > 0) chk("redispatch_core", ci, start_q.pop_front());
               active[ci] = 1'b1;
               held[ci]   = hold_mode;
               cnonce[ci] = core_nonce[8:0];
               cnt[ci]    = rand_lat ? int'($urandom_range(1, 14)) : lat[ci];
               exp_nonce++;
            end
         end
      end
   end

   // Monitor: every write must match an outstanding result; done must close a full run.
   initial begin
      int idx;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            exp_q.delete();
            ord_q.delete();
            ord_last = -1;
            wr_run   = 0;
         end else begin
            if (mem_we) begin
               idx = -1;
               wr_total++;
               wr_run++;
               last_wr = cyc;
               foreach (exp_q[j]) if (idx < 0 && exp_q[j].addr == mem_addr) idx = j;
               if (idx < 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: addr %h data %h has no outstanding result", mem_addr, mem_write_data);
               end else begin
                  chk("write_data", mem_write_data, exp_q[idx].data);
                  if (strict) begin
                     chk("write_order", idx, 0);
                     chk("write_latency", cyc - exp_q[idx].cyc, 2);
                  end
                  exp_q.delete(idx);
               end
               if (ord_q.size() > 0) begin
                  chk("rr_order", 32'(mem_addr), 32'(ord_q.pop_front()));
                  if (ord_last >= 0) chk("rr_back_to_back", cyc - ord_last, 1);
                  ord_last = (ord_q.size() > 0) ? cyc : -1;
               end
            end
            if (done) begin
               chk("done_writes", wr_run, NN);
               chk("done_timing", cyc - last_wr, 1);
               chk("done_leftover", exp_q.size(), 0);
               done_cnt++;
               wr_run = 0;
            end
         end
      end
   end

   task automatic wait_writes(input int target, input string name);
      int k = 0;
      while (wr_total < target && k < 3000) begin
         @(negedge clk); #2;
         k++;
      end
      if (wr_total < target) tfail(name);
   endtask

   task automatic wait_active(input logic [NC-1:0] m, input string name);
      int k = 0;
      while (active != m && k < 500) begin
         @(negedge clk); #2;
         k++;
      end
      if (active != m) tfail(name);
   endtask

   task automatic do_run(input logic [15:0] b);
      int d0;
      int k;
      d0 = done_cnt;
      k  = 0;
      base = b;
      output_addr = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("first_core_start", 32'(core_start), 32'd1);
      chk("first_core_nonce", core_nonce, 32'd0);
      while (done_cnt == d0 && k < 3000) begin
         @(negedge clk); #2;
         k++;
      end
      if (done_cnt == d0) tfail("run_done");
      repeat (3) @(negedge clk);
      #2;
      chk("single_done", done_cnt - d0, 1);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_core_start"}, 32'(core_start), 0);
      chk({tag, "_core_nonce"}, core_nonce, 0);
      chk({tag, "_mem_we"}, 32'(mem_we), 0);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
      chk({tag, "_mem_data"}, mem_write_data, 0);
   endtask

   initial begin
      int w0;
      logic [15:0] b;
      #1 reset_n = 1'b0;
      #1 chk_outputs_zero("reset");
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b1;
      inj_seq++;
      repeat (4) @(negedge clk);
      #2;

      // Basic sweep and address wrap with fixed latency: in-order, 2-cycle write latency.
      strict = 1'b1;
      do_run(16'h0100);
      do_run(16'hFFFC);
      strict = 1'b0;

      // Out-of-order completion.
      lat = '{20, 5, 12, 3};
      do_run(16'h2000);

      // Simultaneous completion with the round-robin pointer at core 2.
      hold_mode = 1'b1;
      fork
         do_run(16'h3000);
         begin
            wait_active(4'hF, "hold_fill");
            w0 = wr_total;
            rel_mask = 4'b0010;
            rel_seq++;
            wait_writes(w0 + 1, "core1_write");
            wait_active(4'hF, "hold_refill");
            ord_q.push_back(16'h3002);
            ord_q.push_back(16'h3003);
            ord_q.push_back(16'h3000);
            ord_q.push_back(16'h3004);
            start_q.push_back(2);
            start_q.push_back(3);
            start_q.push_back(0);
            start_q.push_back(1);
            rel_mask = 4'hF;
            rel_seq++;
            wait_writes(w0 + 5, "burst_writes");
            wait_active(4'hF, "burst_redispatch");
            chk("redispatch_all", start_q.size(), 0);
            lat = '{3, 3, 3, 3};
            hold_mode = 1'b0;
            rel_seq++;
         end
      join

      // Reset mid-run, then a clean restart.
      rand_lat = 1'b1;
      w0 = wr_total;
      b = 16'($urandom);
      base = b;
      output_addr = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_writes(w0 + 6, "pre_reset_writes");
      reset_n = 1'b0;
      #1 chk_outputs_zero("midrun_reset");
      @(negedge clk);
      #2 reset_n = 1'b1;
      repeat (5) @(negedge clk);
      #2;
      chk("no_write_after_reset", wr_total - w0, 6);
      do_run(16'($urandom));

      // Illegal events: start during RUN, core_done on idle cores.
      rand_lat = 1'b0;
      lat = '{6, 6, 6, 6};
      w0 = wr_total;
      fork
         do_run(16'h4000);
         begin
            wait_writes(w0 + 3, "ill_start_point");
            start = 1'b1;
            output_addr = 16'hBEEF;
            repeat (3) @(negedge clk);
            start = 1'b0;
            wait_writes(w0 + 13, "ill_inject_point");
            repeat (4) begin
               inj_seq++;
               repeat (2) @(negedge clk);
            end
         end
      join
      chk("illegal_total_writes", wr_total - w0, NN);

      // Randomized latencies and bases.
      rand_lat = 1'b1;
      repeat (3) do_run(16'($urandom));

      repeat (5) @(negedge clk);
      chk("final_queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #600000;
      errors++;
      $display("FAIL watchdog: simulation did not complete");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
